lvds_rx_frame: RTL
==================

// Module: lvds_rx_frame
// PURPOSE
//  Frame deframer directly downstream of the LVDS data recovery unit. Takes the recovered
//  nibble stream (nibble strobe + last flag), packs nibbles into bytes, and parses fixed
//  frames: 1 address byte, DBYTES data bytes big-endian, 1 CRC-8 byte.
//  Emits one write pulse per good frame to the register/bus side, and counts length and CRC
//  errors for status readback.
// PARAMETERS
//  DBYTES   4   data payload bytes per frame (1..8); o_d width = 8*DBYTES
//  CNTW     8   width of the saturating error counters
// PORTS
//  c            in   1          clock, 400 MHz, same domain as the recovery unit
//  r            in   1          synchronous active-high reset
//  i_d          in   4          recovered nibble, MS nibble of each byte first
//  i_s          in   1          nibble strobe; i_d is valid when high
//  i_last       in   1          qualifies i_s: this nibble ends the frame
//  o_v          out  1          one-cycle pulse: good frame, o_a/o_d valid
//  o_a          out  8          frame address byte
//  o_d          out  8*DBYTES   frame data, first received byte in MSBs
//  o_crc_err    out  CNTW       saturating count of CRC failures
//  o_len_err    out  CNTW       saturating count of wrong-length frames
// BEHAVIOUR
//  - Reset (r=1 at a clock edge): o_v=0, o_a=0, o_d=0, both counters=0, nibble count=0,
//    CRC=0x00, phase=HIGH. Reset mid-frame discards the partial frame; no pulse, no count.
//  - i_s may assert on any cycle, including back-to-back. Nominal input rate is 1 per 2 clocks.
//  - Nibble phase: HIGH nibble goes to byte[7:4]. The LOW nibble completes the byte.
//  - Nibble counter: saturates at 2*(DBYTES+2)+1. It is cleared after the frame end.
//  - Byte k=0 goes to the address register. Bytes k=1..DBYTES shift into the data shift
//    register. Byte DBYTES+1 is the CRC byte. Bytes beyond that are ignored.
//  - CRC-8: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR.
//    CRC runs over all bytes including the CRC byte. A good frame leaves remainder 0x00.
//    It is updated one byte per completed byte (byte-wide combinational step).
//  - Frame end = i_s && i_last.
//    Stage E1 (next edge): capture final byte, CRC, address, data, and length_ok into a
//    snapshot. length_ok is true iff the nibble count including this nibble is
//    exactly 2*(DBYTES+2). Live frame state is reset for the next frame in the same edge.
//    Stage E2 (following edge):
//    - length_ok && crc==0 -> o_v=1 for one cycle, o_a/o_d loaded.
//    - !length_ok -> o_len_err++ (length is checked first; CRC is not checked).
//    - else -> o_crc_err++.
//  - Latency: o_v rises exactly 2 clocks after the edge sampling i_s&&i_last.
//  - A new frame may start on the cycle right after a frame end. The snapshot isolates it.
//  - o_a/o_d hold their last good values between pulses. They are updated only with o_v.
//  - Counters saturate at 2**CNTW-1 and never wrap.
//  - i_last without i_s is ignored. An empty frame is impossible, since the last nibble is counted.
// STRUCTURE
//  - Shared package lvds_pkg: CRC8_POLY=8'h07, function crc8_byte(crc,byte).
//    The same package serves the TX framer.
//  - One sub-module, lvds_crc8: combinational byte step wrapped in a register.
//    It has inputs clr and en.
//  - Top level holds the nibble packer, counter, E1 snapshot, E2 check, and counters.
// TESTING
//  1 DBYTES=4. Nibbles 0,1,0,0,0,0,0,0,0,0,6,2 at 1 per 2 clks, last on final
//    -> o_v pulse 2 clks after last; o_a=8'h01, o_d=32'h0; counters stay 0.
//  2 Same frame with CRC byte 0x63 -> no o_v; o_crc_err=1; o_a/o_d unchanged.
//  3 11 nibbles, then 13 nibbles, each ending with last -> o_len_err=2, no o_v,
//    o_crc_err=0.
//  4 Good frame immediately followed (next cycle, i_s every clock) by a second good frame:
//    addr 0x00, data 0, CRC 0x00 -> two o_v pulses, second carries o_a=0, o_d=0.
//  5 r asserted after 5 nibbles, then a full good frame -> exactly one o_v, counters 0.
//  6 CNTW=2: five bad-CRC frames -> o_crc_err saturates at 3.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared LVDS link definitions: CRC-8 polynomial and the byte-wide CRC step.
// Used by both the RX deframer and the TX framer.
package lvds_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first, unreflected CRC-8 update over one whole byte.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] v;
        v = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            v = v[7] ? ({v[6:0], 1'b0} ^ CRC8_POLY) : {v[6:0], 1'b0};
        end
        return v;
    endfunction

endpackage

// File: rtl/lvds_crc8.sv
// Running CRC-8 register, advanced one byte per enabled cycle.
// o_crc_nxt exposes the value including the current byte so a frame end can snapshot it.
module lvds_crc8
    import lvds_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc_nxt
);

    logic [7:0] r_crc;

    assign o_crc_nxt = i_en ? crc8_byte(r_crc, i_byte) : r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_crc <= '0;
        end else begin
            r_crc <= o_crc_nxt;
        end
    end

endmodule

// File: rtl/lvds_rx_frame.sv
// LVDS frame deframer: packs recovered nibbles into bytes, parses addr/data/CRC frames,
// emits one write pulse per good frame and counts length/CRC errors.
module lvds_rx_frame
    import lvds_pkg::*;
#(
    parameter int DBYTES = 4,
    parameter int CNTW   = 8
) (
    input  logic                  c,
    input  logic                  r,
    input  logic [3:0]            i_d,
    input  logic                  i_s,
    input  logic                  i_last,
    output logic                  o_v,
    output logic [7:0]            o_a,
    output logic [8*DBYTES-1:0]   o_d,
    output logic [CNTW-1:0]       o_crc_err,
    output logic [CNTW-1:0]       o_len_err
);

    localparam int NFULL = 2 * (DBYTES + 2);
    localparam int NMAX  = NFULL + 1;
    localparam int NW    = $clog2(NMAX + 1);
    localparam int DW    = 8 * DBYTES;

    localparam logic [NW-1:0] NFULL_V = NW'(NFULL);
    localparam logic [NW-1:0] NMAX_V  = NW'(NMAX);
    localparam logic [NW-2:0] K_DLAST = (NW-1)'(DBYTES);
    localparam logic [NW-2:0] K_CRC   = (NW-1)'(DBYTES + 1);

    logic            r_phase;
    logic [3:0]      r_hi;
    logic [NW-1:0]   r_ncnt;
    logic [7:0]      r_addr;
    logic [DW-1:0]   r_dsh;

    logic            r_s_pend, r_s_lok;
    logic [7:0]      r_s_crc, r_s_addr;
    logic [DW-1:0]   r_s_data;

    logic            r_p_good, r_p_lerr, r_p_cerr;
    logic [7:0]      r_p_addr;
    logic [DW-1:0]   r_p_data;

    logic            r_v;
    logic [7:0]      r_a;
    logic [DW-1:0]   r_d;
    logic [CNTW-1:0] r_crc_err, r_len_err;

    logic            w_end, w_bdone, w_crc_en;
    logic [7:0]      w_byte, w_crc_nxt, w_addr_nxt;
    logic [NW-1:0]   w_ncnt_nxt;
    logic [NW-2:0]   w_k;
    logic [DW+7:0]   w_sh;
    logic [DW-1:0]   w_dsh_nxt;

    assign w_end      = i_s & i_last;
    assign w_byte     = {r_hi, i_d};
    assign w_bdone    = i_s & r_phase;
    assign w_k        = r_ncnt[NW-1:1];
    assign w_crc_en   = w_bdone && (w_k <= K_CRC);
    assign w_ncnt_nxt = (r_ncnt == NMAX_V) ? r_ncnt : r_ncnt + 1'b1;
    assign w_sh       = {r_dsh, w_byte};

    always_comb begin
        w_addr_nxt = r_addr;
        w_dsh_nxt  = r_dsh;
        if (w_bdone && w_k == '0) begin
            w_addr_nxt = w_byte;
        end
        if (w_bdone && w_k != '0 && w_k <= K_DLAST) begin
            w_dsh_nxt = w_sh[DW-1:0];
        end
    end

    lvds_crc8 u_crc (
        .i_clk     (c),
        .i_rst     (r),
        .i_clr     (w_end),
        .i_en      (w_crc_en),
        .i_byte    (w_byte),
        .o_crc_nxt (w_crc_nxt)
    );

    always_ff @(posedge c) begin
        if (r) begin
            r_phase   <= 1'b0;
            r_hi      <= '0;
            r_ncnt    <= '0;
            r_addr    <= '0;
            r_dsh     <= '0;
            r_s_pend  <= 1'b0;
            r_s_lok   <= 1'b0;
            r_s_crc   <= '0;
            r_s_addr  <= '0;
            r_s_data  <= '0;
            r_p_good  <= 1'b0;
            r_p_lerr  <= 1'b0;
            r_p_cerr  <= 1'b0;
            r_p_addr  <= '0;
            r_p_data  <= '0;
            r_v       <= 1'b0;
            r_a       <= '0;
            r_d       <= '0;
            r_crc_err <= '0;
            r_len_err <= '0;
        end else begin
            if (w_end) begin
                r_phase <= 1'b0;
                r_ncnt  <= '0;
                r_addr  <= '0;
                r_dsh   <= '0;
            end else begin
                if (i_s) begin
                    r_phase <= ~r_phase;
                    r_ncnt  <= w_ncnt_nxt;
                    if (!r_phase) r_hi <= i_d;
                end
                r_addr <= w_addr_nxt;
                r_dsh  <= w_dsh_nxt;
            end

            // Snapshot frees the live state so a new frame can start next cycle.
            r_s_pend <= w_end;
            if (w_end) begin
                r_s_lok  <= (w_ncnt_nxt == NFULL_V);
                r_s_crc  <= w_crc_nxt;
                r_s_addr <= w_addr_nxt;
                r_s_data <= w_dsh_nxt;
            end

            r_p_good <= r_s_pend & r_s_lok & (r_s_crc == 8'h00);
            r_p_lerr <= r_s_pend & ~r_s_lok;
            r_p_cerr <= r_s_pend & r_s_lok & (r_s_crc != 8'h00);
            r_p_addr <= r_s_addr;
            r_p_data <= r_s_data;

            r_v <= r_p_good;
            if (r_p_good) begin
                r_a <= r_p_addr;
                r_d <= r_p_data;
            end
            if (r_p_lerr && r_len_err != '1) r_len_err <= r_len_err + 1'b1;
            if (r_p_cerr && r_crc_err != '1) r_crc_err <= r_crc_err + 1'b1;
        end
    end

    assign o_v       = r_v;
    assign o_a       = r_a;
    assign o_d       = r_d;
    assign o_crc_err = r_crc_err;
    assign o_len_err = r_len_err;

endmodule
